// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared types and constants for the RV32M multiply/divide issue controller.
package mdu_issue_ctrl_pkg;

   localparam logic [6:0] OPC_OP   = 7'b0110011;
   localparam logic [6:0] M_FUNCT7 = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

   localparam int MUL_LAT_DEF = 2;
   localparam int DIV_LAT_DEF = 8;

   typedef logic [31:0] data_t;

   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rd;
      logic [2:0] funct3;
      logic [6:0] opcode;
   } instr_t;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_t;

   function automatic logic [39:0] ext40(data_t v, logic sgn);
      return {{8{sgn & v[31]}}, v};
   endfunction

   function automatic logic rs1_signed(logic [2:0] f3);
      return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
   endfunction

   function automatic logic rs2_signed(logic [2:0] f3);
      return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/mdu_issue_ctrl_if.sv
// Execute-stage and datapath handshake bundle for the M-op issue controller.
interface mdu_issue_ctrl_if import mdu_issue_ctrl_pkg::*; ();
   logic          valid_in;
   logic          flush;
   instr_t        instr;
   data_t         a_in;
   data_t         b_in;
   logic          stall_out;
   logic          done;
   data_t         c_out;
   logic [39:0]   dp_a;
   logic [39:0]   dp_b;
   logic [79:0]   dp_mul_result;
   logic [39:0]   dp_quot;
   logic [39:0]   dp_rem;

   modport slave (
      input  valid_in, flush, instr, a_in, b_in, dp_mul_result, dp_quot, dp_rem,
      output stall_out, done, c_out, dp_a, dp_b
   );

   modport master (
      output valid_in, flush, instr, a_in, b_in, dp_mul_result, dp_quot, dp_rem,
      input  stall_out, done, c_out, dp_a, dp_b
   );
endinterface

// File: rtl/mdu_issue_ctrl_special_case.sv
// Divide-by-zero and signed-overflow results that never need the divider.
module mdu_special_case import mdu_issue_ctrl_pkg::*; (
   input  logic [2:0] funct3,
   input  data_t      a,
   input  data_t      b,
   output logic       is_special,
   output data_t      special_result
);
   // funct3[2]: divide class, funct3[1]: remainder, funct3[0]: unsigned
   always_comb begin
      is_special     = 1'b0;
      special_result = '0;
      if (funct3[2] && b == '0) begin
         is_special     = 1'b1;
         special_result = funct3[1] ? a : 32'hFFFF_FFFF;
      end else if (funct3[2] && !funct3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         is_special     = 1'b1;
         special_result = funct3[1] ? 32'h0 : 32'h8000_0000;
      end
   end
endmodule

// File: rtl/mdu_issue_ctrl.sv
// RV32M issue controller: latches operands, counts datapath latency, stalls
// the pipeline and returns a registered result.
module mdu_issue_ctrl import mdu_issue_ctrl_pkg::*; #(
   parameter int MUL_LAT = MUL_LAT_DEF,
   parameter int DIV_LAT = DIV_LAT_DEF
) (
   input logic          clk,
   input logic          rst,
   mdu_issue_ctrl_if.slave bus
);
   localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(LAT_MAX + 1);

   mdu_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       op;
   logic             is_m, accept, last, is_special;
   data_t            special_result, result_sel;
   logic             unused_bits;

   assign is_m   = (bus.instr.opcode == OPC_OP) && (bus.instr.funct7 == M_FUNCT7);
   assign accept = (state == IDLE) && bus.valid_in && is_m && !bus.flush;
   assign last   = (state == BUSY) && (cnt == CNT_W'(1));

   assign unused_bits = ^{bus.dp_mul_result[79:64], bus.dp_quot[39:32],
                          bus.dp_rem[39:32], bus.instr.rd};

   mdu_special_case u_special (
      .funct3         (bus.instr.funct3),
      .a              (bus.a_in),
      .b              (bus.b_in),
      .is_special     (is_special),
      .special_result (special_result)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = is_special ? DONE : BUSY;
         BUSY:    if (bus.flush) state_nxt = IDLE;
                  else if (last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.stall_out = bus.valid_in && is_m && (state != DONE) && !bus.flush;
   end

   always_comb begin
      result_sel = bus.dp_rem[31:0];
      unique case (op)
         F3_MUL:                       result_sel = bus.dp_mul_result[31:0];
         F3_MULH, F3_MULHSU, F3_MULHU: result_sel = bus.dp_mul_result[63:32];
         F3_DIV, F3_DIVU:              result_sel = bus.dp_quot[31:0];
         default:                      result_sel = bus.dp_rem[31:0];
      endcase
   end

   // Operands stay frozen from accept until the next accept so the datapath sees stable inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         op        <= '0;
         bus.dp_a  <= '0;
         bus.dp_b  <= '0;
         bus.c_out <= '0;
         bus.done  <= 1'b0;
      end else begin
         bus.done <= (state_nxt == DONE);
         if (bus.flush) begin
            cnt <= '0;
         end else if (accept && !is_special) begin
            cnt      <= bus.instr.funct3[2] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
            op       <= bus.instr.funct3;
            bus.dp_a <= ext40(bus.a_in, rs1_signed(bus.instr.funct3));
            bus.dp_b <= ext40(bus.b_in, rs2_signed(bus.instr.funct3));
         end else if (state == BUSY) begin
            cnt <= cnt - CNT_W'(1);
         end
         if (accept && is_special)
            bus.c_out <= special_result;
         else if (last && !bus.flush)
            bus.c_out <= result_sel;
      end
   end
endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Self-checking bench for mdu_issue_ctrl: directed table, corner sequences, random ops vs. reference model.
module tb_mdu_issue_ctrl;
   import mdu_issue_ctrl_pkg::*;

   localparam int MUL_LAT = 2;
   localparam int DIV_LAT = 8;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   data_t       last_c;
   logic [39:0] last_dpa, last_dpb;
   bit          dp_known;

   mdu_issue_ctrl_if bus();

   mdu_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Ideal datapath: results follow dp_a/dp_b instantly.
   logic signed [39:0] dsa, dsb;
   always_comb begin
      dsa = $signed(bus.dp_a);
      dsb = $signed(bus.dp_b);
      bus.dp_mul_result = 80'(dsa) * 80'(dsb);
      bus.dp_quot = (dsb == 0) ? 40'h0 : 40'(dsa / dsb);
      bus.dp_rem  = (dsb == 0) ? 40'h0 : 40'(dsa % dsb);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic data_t ref_result(input logic [2:0] f3, input data_t a, input data_t b);
      longint sa, sb, ua, ub, t;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      up = 64'(ua) * 64'(ub);
      case (f3)
         F3_MUL:    t = sa * sb;
         F3_MULH:   t = (sa * sb) >>> 32;
         F3_MULHSU: t = (sa * ub) >>> 32;
         F3_MULHU:  t = longint'(up >> 32);
         F3_DIV:    t = (b == 0) ? -1 : sa / sb;
         F3_DIVU:   t = (b == 0) ? -1 : ua / ub;
         F3_REM:    t = (b == 0) ? sa : sa % sb;
         default:   t = (b == 0) ? ua : ua % ub;
      endcase
      return t[31:0];
   endfunction

   function automatic bit ref_special(input logic [2:0] f3, input data_t a, input data_t b);
      bit is_div = (f3 >= F3_DIV);
      bit signed_div = (f3 == F3_DIV) || (f3 == F3_REM);
      return (is_div && b == 0) || (signed_div && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   function automatic int ref_lat(input logic [2:0] f3, input data_t a, input data_t b);
      if (ref_special(f3, a, b)) return 1;
      return (f3 >= F3_DIV) ? DIV_LAT + 1 : MUL_LAT + 1;
   endfunction

   function automatic logic [39:0] ref_ext(input data_t v, input bit sgn);
      longint t;
      t = sgn ? longint'($signed(v)) : longint'(v);
      return t[39:0];
   endfunction

   // Starts #1 after a rising edge; returns #1 after the edge following the last checked cycle.
   task automatic run_op(input logic [2:0] f3, input data_t a, input data_t b, input int flush_at,
                         input data_t exp_c, input int exp_cyc, input string nm);
      bit flushed, loads, s1, s2;
      logic [39:0] ea, eb;
      flushed = (flush_at >= 0) && (flush_at < exp_cyc);
      loads   = !ref_special(f3, a, b) && (flush_at != 0);
      s1 = f3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
      s2 = f3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
      ea = loads ? ref_ext(a, s1) : last_dpa;
      eb = loads ? ref_ext(b, s2) : last_dpb;
      bus.valid_in = 1'b1;
      bus.instr    = '{funct7: M_FUNCT7, rd: 5'd1, funct3: f3, opcode: OPC_OP};
      bus.a_in     = a;
      bus.b_in     = b;
      for (int cyc = 0; cyc <= exp_cyc; cyc++) begin
         bus.flush = (cyc == flush_at);
         @(negedge clk);
         chk({nm, " stall"}, 64'(bus.stall_out),
             64'((cyc < exp_cyc) && !(flush_at >= 0 && cyc >= flush_at)));
         chk({nm, " done"}, 64'(bus.done), 64'(!flushed && cyc == exp_cyc));
         if (cyc == 0) chk({nm, " c_out hold"}, 64'(bus.c_out), 64'(last_c));
         if (!flushed && cyc == exp_cyc) begin
            chk({nm, " c_out"}, 64'(bus.c_out), 64'(exp_c));
            if (dp_known || loads) begin
               chk({nm, " dp_a"}, 64'(bus.dp_a), 64'(ea));
               chk({nm, " dp_b"}, 64'(bus.dp_b), 64'(eb));
            end
         end
         @(posedge clk); #1;
         if (cyc == flush_at) bus.valid_in = 1'b0;
      end
      bus.flush = 1'b0;
      if (!flushed) last_c = exp_c;
      if (loads) begin
         last_dpa = ea;
         last_dpb = eb;
         dp_known = !flushed;
      end
   endtask

   task automatic idle(input int n);
      bus.valid_in = 1'b0;
      bus.flush    = 1'b0;
      repeat (n) begin
         @(negedge clk);
         chk("idle stall", 64'(bus.stall_out), 64'h0);
         chk("idle done", 64'(bus.done), 64'h0);
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.valid_in = 1'b0;
      bus.flush    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset done", 64'(bus.done), 64'h0);
      chk("reset c_out", 64'(bus.c_out), 64'h0);
      chk("reset dp_a", 64'(bus.dp_a), 64'h0);
      chk("reset dp_b", 64'(bus.dp_b), 64'h0);
      rst = 1'b0;
      last_c = '0; last_dpa = '0; last_dpb = '0; dp_known = 1'b1;
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [2:0] f3;
      data_t      a, b, c;
      int         cyc;
      string      nm;
   } vec_t;

   vec_t tbl[$];

   initial begin
      bus.instr = '0; bus.a_in = '0; bus.b_in = '0;
      tbl.push_back('{F3_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF, 1, "divu_by0"});
      tbl.push_back('{F3_REMU,   32'd5,          32'd0,          32'd5,         1, "remu_by0"});
      tbl.push_back('{F3_MUL,    32'd7,          32'hFFFF_FFFD,  32'hFFFF_FFEB, 3, "mul_7x-3"});
      tbl.push_back('{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 3, "mulhu_max"});
      tbl.push_back('{F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 3, "mulhsu_m1"});
      tbl.push_back('{F3_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 3, "mulh_min"});
      tbl.push_back('{F3_DIV,    32'hFFFF_FFEC,  32'd6,          32'hFFFF_FFFD, 9, "div_-20/6"});
      tbl.push_back('{F3_REM,    32'hFFFF_FFEC,  32'd6,          32'hFFFF_FFFE, 9, "rem_-20/6"});
      tbl.push_back('{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1, "div_ovf"});
      tbl.push_back('{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'h0,         1, "rem_ovf"});
      tbl.push_back('{F3_DIVU,   32'd100,        32'd7,          32'd14,        9, "divu_100/7"});
      tbl.push_back('{F3_REMU,   32'd100,        32'd7,          32'd2,         9, "remu_100/7"});
      tbl.push_back('{F3_DIV,    32'd5,          32'd0,          32'hFFFF_FFFF, 1, "div_by0"});
      tbl.push_back('{F3_REM,    32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9, 1, "rem_by0"});

      do_reset();

      // Back-to-back: each op is presented the cycle after the previous done.
      foreach (tbl[i]) run_op(tbl[i].f3, tbl[i].a, tbl[i].b, -1, tbl[i].c, tbl[i].cyc, tbl[i].nm);
      idle(1);

      // Non-M ops must be ignored.
      bus.valid_in = 1'b1;
      bus.instr = '{funct7: 7'h00, rd: 5'd2, funct3: F3_MUL, opcode: OPC_OP};
      @(negedge clk); chk("nonm stall", 64'(bus.stall_out), 64'h0);
      @(posedge clk); #1;
      bus.instr = '{funct7: M_FUNCT7, rd: 5'd2, funct3: F3_MUL, opcode: 7'b0010011};
      @(negedge clk); chk("nonop stall", 64'(bus.stall_out), 64'h0);
      @(posedge clk); #1;
      idle(2);

      // Flush of an accepted DIV at cycle 4, then flush on the accept cycle and on the capture cycle.
      run_op(F3_DIV, 32'hFFFF_FFEC, 32'd6, 4, 32'h0, 9, "div_flush4");
      run_op(F3_MUL, 32'd3, 32'd4, 0, 32'h0, 3, "mul_flush0");
      run_op(F3_DIVU, 32'd9, 32'd2, 8, 32'h0, 9, "divu_flushlast");
      run_op(F3_MUL, 32'd3, 32'd4, -1, 32'd12, 3, "mul_after_flush");

      // valid_in drops during BUSY: the op still completes.
      bus.valid_in = 1'b1;
      bus.instr = '{funct7: M_FUNCT7, rd: 5'd3, funct3: F3_DIVU, opcode: OPC_OP};
      bus.a_in = 32'd1000; bus.b_in = 32'd33;
      @(negedge clk); chk("vdrop stall0", 64'(bus.stall_out), 64'h1);
      @(posedge clk); #1;
      bus.valid_in = 1'b0;
      for (int c = 1; c <= DIV_LAT + 1; c++) begin
         @(negedge clk);
         chk("vdrop stall", 64'(bus.stall_out), 64'h0);
         chk("vdrop done", 64'(bus.done), 64'(c == DIV_LAT + 1));
         if (c == DIV_LAT + 1) chk("vdrop c_out", 64'(bus.c_out), 64'd30);
         @(posedge clk); #1;
      end
      last_c = 32'd30;
      idle(1);

      // Reset asserted on the done cycle of a MUL clears outputs at once.
      bus.valid_in = 1'b1;
      bus.instr = '{funct7: M_FUNCT7, rd: 5'd4, funct3: F3_MUL, opcode: OPC_OP};
      bus.a_in = 32'd7; bus.b_in = 32'hFFFF_FFFD;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_mid done", 64'(bus.done), 64'h0);
      chk("rst_mid c_out", 64'(bus.c_out), 64'h0);
      chk("rst_mid dp_a", 64'(bus.dp_a), 64'h0);
      bus.valid_in = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      last_c = '0; last_dpa = '0; last_dpb = '0; dp_known = 1'b1;
      idle(2);

      // Random ops against the reference model.
      for (int n = 0; n < 60; n++) begin
         logic [2:0] f3;
         data_t a, b;
         int lat, fl, sel;
         f3  = 3'($urandom_range(0, 7));
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) b = '0;
         else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         else if (sel == 2) b = 32'($urandom_range(1, 15));
         lat = ref_lat(f3, a, b);
         fl  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, lat - 1) : -1;
         run_op(f3, a, b, fl, ref_result(f3, a, b), lat, "rand");
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
